// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issuing pipeline and the RV32M multiply/divide unit.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wen;
  logic        illegal;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out, wen, illegal
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out, wen, illegal
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider.
// Define MULDIV_DIV_EN to include the divider; without it, divide/remainder ops report illegal.
module mul_div_unit (
  input  logic          clk,
  input  logic          reset_n,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_t;

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [4:0]  rd_reg;
  logic [5:0]  cnt_reg;

  logic [63:0] acc_reg;
  logic [63:0] mcand_reg;
  logic [31:0] mplr_reg;
  logic        mplr_neg_reg;

  logic [31:0] result_reg;
  logic [4:0]  rd_out_reg;
  logic        done_reg;
  logic        wen_reg;
  logic        illegal_reg;

  logic        a_signed;
  logic        b_signed;
  logic [63:0] acc_sum;
  logic [63:0] product;

  logic        finish;
  logic [31:0] fin_result;
  logic        fin_illegal;

`ifdef MULDIV_DIV_EN
  logic [31:0] rem_reg;
  logic [31:0] quot_reg;
  logic [31:0] dvsr_reg;
  logic [31:0] dividend_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        div_zero_reg;
  logic        div_ovf_reg;

  logic        d_signed;
  logic        a_neg;
  logic        b_neg;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
`else
  logic        bad_op_reg;
`endif

  assign bus.busy    = (state_reg != ST_IDLE);
  assign bus.done    = done_reg;
  assign bus.result  = result_reg;
  assign bus.rd_out  = rd_out_reg;
  assign bus.wen     = wen_reg;
  assign bus.illegal = illegal_reg;

  // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned
  assign a_signed = ~(bus.funct3[1] & bus.funct3[0]);
  assign b_signed = ~bus.funct3[1];

  // The 33rd multiplier bit carries weight -2^32, so it is applied as a final subtraction.
  always_comb begin
    acc_sum = acc_reg + (mplr_reg[0] ? mcand_reg : 64'd0);
    product = acc_reg - (mplr_neg_reg ? mcand_reg : 64'd0);
  end

`ifdef MULDIV_DIV_EN
  assign d_signed = ~bus.funct3[0];
  assign a_neg    = d_signed & bus.rs1_data[31];
  assign b_neg    = d_signed & bus.rs2_data[31];

  always_comb begin
    shifted  = {rem_reg, quot_reg[31]};
    fits     = (shifted >= {1'b0, dvsr_reg});
    quot_fix = q_neg_reg ? -quot_reg : quot_reg;
    rem_fix  = r_neg_reg ? -rem_reg : rem_reg;
  end
`endif

  always_comb begin
    finish      = 1'b0;
    fin_result  = 32'd0;
    fin_illegal = 1'b0;
    case (state_reg)
      ST_MUL: begin
`ifndef MULDIV_DIV_EN
        if (bad_op_reg) begin
          finish      = 1'b1;
          fin_illegal = 1'b1;
        end else
`endif
        if (cnt_reg == 6'd32) begin
          finish     = 1'b1;
          fin_result = (op_reg == 2'b00) ? product[31:0] : product[63:32];
        end
      end
`ifdef MULDIV_DIV_EN
      ST_DIV: begin
        if (cnt_reg == 6'd0 && div_zero_reg) begin
          finish     = 1'b1;
          fin_result = op_reg[1] ? dividend_reg : 32'hFFFF_FFFF;
        end else if (cnt_reg == 6'd0 && div_ovf_reg) begin
          finish     = 1'b1;
          fin_result = op_reg[1] ? 32'd0 : 32'h8000_0000;
        end else if (cnt_reg == 6'd32) begin
          finish     = 1'b1;
          fin_result = op_reg[1] ? rem_fix : quot_fix;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= 2'd0;
      rd_reg       <= 5'd0;
      cnt_reg      <= 6'd0;
      acc_reg      <= 64'd0;
      mcand_reg    <= 64'd0;
      mplr_reg     <= 32'd0;
      mplr_neg_reg <= 1'b0;
      result_reg   <= 32'd0;
      rd_out_reg   <= 5'd0;
      done_reg     <= 1'b0;
      wen_reg      <= 1'b0;
      illegal_reg  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_reg      <= 32'd0;
      quot_reg     <= 32'd0;
      dvsr_reg     <= 32'd0;
      dividend_reg <= 32'd0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      div_ovf_reg  <= 1'b0;
`else
      bad_op_reg   <= 1'b0;
`endif
    end else begin
      done_reg    <= 1'b0;
      wen_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            op_reg       <= bus.funct3[1:0];
            rd_reg       <= bus.rd_in;
            cnt_reg      <= 6'd0;
            acc_reg      <= 64'd0;
            mcand_reg    <= a_signed ? {{32{bus.rs1_data[31]}}, bus.rs1_data}
                                     : {32'd0, bus.rs1_data};
            mplr_reg     <= bus.rs2_data;
            mplr_neg_reg <= b_signed & bus.rs2_data[31];
`ifdef MULDIV_DIV_EN
            rem_reg      <= 32'd0;
            quot_reg     <= a_neg ? -bus.rs1_data : bus.rs1_data;
            dvsr_reg     <= b_neg ? -bus.rs2_data : bus.rs2_data;
            dividend_reg <= bus.rs1_data;
            q_neg_reg    <= a_neg ^ b_neg;
            r_neg_reg    <= a_neg;
            div_zero_reg <= (bus.rs2_data == 32'd0);
            div_ovf_reg  <= d_signed && (bus.rs1_data == 32'h8000_0000)
                                     && (bus.rs2_data == 32'hFFFF_FFFF);
            state_reg    <= bus.funct3[2] ? ST_DIV : ST_MUL;
`else
            bad_op_reg   <= bus.funct3[2];
            state_reg    <= ST_MUL;
`endif
          end
        end
        ST_MUL: begin
          if (!finish) begin
            acc_reg   <= acc_sum;
            mcand_reg <= mcand_reg << 1;
            mplr_reg  <= mplr_reg >> 1;
            cnt_reg   <= cnt_reg + 6'd1;
          end
        end
`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (!finish) begin
            rem_reg  <= fits ? 32'(shifted - {1'b0, dvsr_reg}) : shifted[31:0];
            quot_reg <= {quot_reg[30:0], fits};
            cnt_reg  <= cnt_reg + 6'd1;
          end
        end
`endif
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase

      if (finish) begin
        state_reg   <= ST_DONE;
        done_reg    <= 1'b1;
        result_reg  <= fin_result;
        rd_out_reg  <= rd_reg;
        wen_reg     <= (rd_reg != 5'd0) && !fin_illegal;
        illegal_reg <= fin_illegal;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, random ops against an arithmetic model, mid-op reset.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp [5];
    sp[0] = 32'h0;
    sp[1] = 32'h1;
    sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000;
    sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Called at a falling edge; returns at the falling edge of the first IDLE cycle after DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int repulse_at);
    logic [31:0] exp_res;
    int          exp_lat;
    logic        exp_ill;
    int          edges;
    int          busy_drops;
    bit          seen;

    if (f[2] && !DIV_EN) begin
      exp_res = 32'd0;
      exp_ill = 1'b1;
      exp_lat = 1;
    end else begin
      exp_res = ref_result(f, a, b);
      exp_ill = 1'b0;
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
        exp_lat = 1;
      else
        exp_lat = 33;
    end

    bus.funct3   = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.funct3   = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_in    = 5'($urandom);

    edges      = 0;
    busy_drops = 0;
    seen       = 1'b0;
    while (edges < 64 && !seen) begin
      bus.start = (edges == repulse_at - 1);
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_drops++;
    end
    bus.start = 1'b0;

    check("timeout", 32'(seen), 32'd1);
    check("latency", 32'(edges), 32'(exp_lat));
    check("busy_during", 32'(busy_drops), 32'd0);
    check("busy_at_done", 32'(bus.busy), 32'd1);
    check("result", bus.result, exp_res);
    check("rd_out", 32'(bus.rd_out), 32'(rd));
    check("wen", 32'(bus.wen), 32'((rd != 0) && !exp_ill));
    check("illegal", 32'(bus.illegal), 32'(exp_ill));
    $display("op f=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d (exp %h lat %0d)",
             f, a, b, rd, bus.result, edges, exp_res, exp_lat);

    @(negedge clk);
    check("done_clear", 32'(bus.done), 32'd0);
    check("busy_clear", 32'(bus.busy), 32'd0);
    check("result_hold", bus.result, exp_res);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    bit          spurious;

    bus.start    = 1'b0;
    bus.funct3   = 3'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.rd_in    = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wen", 32'(bus.wen), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd_out", 32'(bus.rd_out), 32'd0);
    reset_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd10, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 0);
    run_op(3'd0, 32'd123, 32'd456, 5'd0, 10);
`ifdef MULDIV_DIV_EN
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
    run_op(3'd5, 32'd100, 32'd0, 5'd3, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0);
    run_op(3'd7, 32'd1234, 32'd0, 5'd6, 0);
`else
    run_op(3'd4, 32'd8, 32'd2, 5'd3, 0);
    run_op(3'd7, 32'd9, 32'd4, 5'd0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
      run_op(f, a, b, 5'($urandom), 0);
    end

    // Abort an operation with an asynchronous reset partway through.
    run_op(3'd0, 32'd5, 32'd5, 5'd2, 0);
`ifdef MULDIV_DIV_EN
    bus.funct3 = 3'd4;
`else
    bus.funct3 = 3'd0;
`endif
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd7;
    bus.rd_in    = 5'd4;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_result", bus.result, 32'd0);
    check("async_rd_out", 32'(bus.rd_out), 32'd0);
    spurious = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.wen || bus.busy) spurious = 1'b1;
    end
    check("reset_quiet", 32'(spurious), 32'd0);
    reset_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, 5'd6, 0);
    check("after_reset_mul", bus.result, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port rs1_data  input  32  operand A, taken from register-file rdata1.
REQ-006 SHALL have port rs2_data  input  32  operand B, taken from register-file rdata2.
REQ-007 SHALL have port rd_in  input  5  destination register index.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port result  output  32  final value, held until next done.
REQ-011 SHALL have port rd_out  output  5  captured rd_in, held with result.
REQ-012 SHALL have port wen  output  1  register-file write enable (register file writes on falling edge).
REQ-013 SHALL have port illegal  output  1  one-cycle pulse; unsupported op (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE; busy = (state != IDLE).
REQ-015 In IDLE with start=1, SHALL capture funct3, both operands and rd_in at the edge, then enter MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-016 start SHALL be ignored while busy; operand inputs need not remain stable after capture.
REQ-017 MUL SHALL perform iterative shift-add on 33-bit sign/zero-extended operands (signedness per funct3), one bit per cycle, 32 cycles, 64-bit product.
REQ-018 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-019 DIV SHALL perform restoring division on operand magnitudes, one quotient bit per cycle, 32 cycles; signs corrected on exit (quotient negative iff signs differ, remainder takes dividend sign).
REQ-020 After the final iteration SHALL enter DONE for exactly one cycle, then IDLE; normal latency: start edge E0 -> done high in the cycle after edge E33 -> busy low after edge E34.
REQ-021 Divide by zero SHALL bypass iteration (DONE entered at E1): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = rs1_data.
REQ-022 Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF) SHALL bypass iteration: DIV result 0x80000000, REM result 0.
REQ-023 In DONE: done=1, result and rd_out valid; wen=1 only when rd_out != 0 (x0 never written).
REQ-024 result and rd_out SHALL hold their values until the next DONE cycle.
REQ-025 A back-to-back start SHALL be accepted in the first IDLE cycle after DONE.

Reset
REQ-026 reset_n low SHALL immediately, without a clock, force state IDLE and busy, done, wen and illegal to 0, and result and rd_out to 0.
REQ-027 Reset mid-operation SHALL abort the operation with no done and no wen.
REQ-028 After reset_n rises, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: all eight ops are supported; illegal stays 0.
REQ-030 Macro MULDIV_DIV_EN undefined: the DIV state and divider datapath SHALL be absent; funct3[2]=1 goes directly to DONE (done at E1) with result 0, wen=0, and illegal pulsed with done.

Verification
REQ-031 MUL 7 x -3, rd=5 -> done after edge E33, result 0xFFFFFFEB, wen=1, rd_out=5.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU -1 x 2 -> result 0xFFFFFFFF.
REQ-033 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF at E1; REM 0x80000000 / -1 -> 0.
REQ-034 MUL with rd=0 -> done=1, wen=0; start pulsed again at E10 while busy -> ignored, single done.
REQ-035 reset_n low at E15 of a DIV -> busy=0 asynchronously, no done; new MUL 3 x 4 after release -> result 12.
REQ-036 Build with MULDIV_DIV_EN undefined: DIV 8 / 2 -> done and illegal at E1, result 0, wen=0.
